mp3_play_sched: RTL and testbench

Playback scheduler between the digit recognizer and the MP3 SPI driver. It queues recognized digit decisions in a small FIFO and issues them to the driver one at a time. It holds the driver in reset while no clip is playing and releases it for one clip per decision. It enforces an inter-clip gap and aborts a clip whose driver never reports completion.

---
 rtl/mp3_play_sched_pkg.sv | 21 ++
 rtl/mp3_sched_fifo.sv | 45 ++++
 rtl/mp3_play_sched.sv | 153 +++++++++++++++
 tb/tb_mp3_play_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_play_sched_pkg.sv
// Shared types and constants for the MP3 playback scheduler.
package mp3_play_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StPlay,
        StGap
    } sched_state_e;

    localparam logic [3:0] MaxDigit = 4'd9;

    localparam int unsigned DefaultGapCycles     = 1000;
    localparam int unsigned DefaultTimeoutCycles = 50_000_000;

    // Counter width wide enough for the longer of the two intervals, plus headroom.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/mp3_sched_fifo.sv
// Synchronous 4-bit FIFO for queued digit decisions; head is read from registered storage.
module mp3_sched_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [3:0] wdata_i,
    output logic [3:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [3:0]  mem_q [Depth];
    logic [AW:0] wptr_q, rptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mp3_play_sched.sv
// Queues recognized digits and plays them one clip at a time through the MP3 driver.
// Optional MP3_SCHED_DEDUP_EN drops a repeat of the last accepted digit while busy.
module mp3_play_sched
    import mp3_play_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [3:0] decision,
    input  logic       play_done,
    output logic       drv_rst,
    output logic [3:0] drv_digit,
    output logic       busy,
    output logic       overflow,
    output logic       bad_digit,
    output logic       timeout
);

    localparam int unsigned    CntW        = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);

    sched_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      digit_q, digit_d;
    logic            drv_rst_q, busy_q, overflow_q, bad_digit_q, timeout_q;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [3:0] fifo_head;
    logic       legal, dup, ovf_drop, timeout_set;

    assign legal = (decision <= MaxDigit);

`ifdef MP3_SCHED_DEDUP_EN
    logic [3:0] last_q;

    assign dup = busy_q && (decision == last_q);

    // Reset value 4'hF can never equal a legal digit, so the first decision always passes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 4'hF;
        end else if (fifo_push) begin
            last_q <= decision;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign fifo_push = valid_in && legal && !dup && (!fifo_full || fifo_pop);
    assign ovf_drop  = valid_in && legal && !dup && fifo_full && !fifo_pop;

    mp3_sched_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (decision),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        fifo_pop    = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    digit_d  = fifo_head;
                    state_d  = StStart;
                end
            end
            StStart: begin
                state_d = StPlay;
                cnt_d   = '0;
            end
            StPlay: begin
                if (play_done) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    timeout_set = 1'b1;
                    state_d     = StGap;
                    cnt_d       = '0;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            digit_q     <= 4'd0;
            drv_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            bad_digit_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            // Driver runs only in setup and playback; decoded from the next state for glitch-free output.
            drv_rst_q <= !((state_d == StStart) || (state_d == StPlay));
            busy_q    <= (state_q != StIdle) || !fifo_empty;
            if (valid_in && !legal) begin
                bad_digit_q <= 1'b1;
            end
            if (ovf_drop) begin
                overflow_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign drv_rst   = drv_rst_q;
    assign drv_digit = digit_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign bad_digit = bad_digit_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mp3_play_sched.sv
// Self-checking bench for mp3_play_sched: per-cycle queue model plus directed literal checks.
module tb_mp3_play_sched;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Gap     = 5;
    localparam int unsigned Timeout = 100;
`ifdef MP3_SCHED_DEDUP_EN
    localparam bit Dedup = 1'b1;
`else
    localparam bit Dedup = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [3:0] decision = 4'd0;
    logic       play_done = 1'b0;
    logic       drv_rst;
    logic [3:0] drv_digit;
    logic       busy, overflow, bad_digit, timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int clips[$];

    mp3_play_sched #(
        .FIFO_DEPTH     (Depth),
        .GAP_CYCLES     (Gap),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .decision  (decision),
        .play_done (play_done),
        .drv_rst   (drv_rst),
        .drv_digit (drv_digit),
        .busy      (busy),
        .overflow  (overflow),
        .bad_digit (bad_digit),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Model: a digit queue, a clip in progress (setup cycle then play cycles), and a rest period.
    int         m_q[$];
    bit         m_clip = 1'b0;
    int         m_age = 0;
    int         m_rest = 0;
    logic [3:0] m_digit = 4'd0;
    logic [3:0] m_last = 4'hF;
    bit         m_busy = 1'b0, m_ovf = 1'b0, m_bad = 1'b0, m_to = 1'b0;

    initial forever begin
        bit idle, nxt_busy;
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_clip = 1'b0; m_age = 0; m_rest = 0; m_digit = 4'd0; m_last = 4'hF;
            m_busy = 1'b0; m_ovf = 1'b0; m_bad = 1'b0; m_to = 1'b0;
        end else begin
            idle     = !m_clip && (m_rest == 0);
            nxt_busy = !idle || (m_q.size() != 0);
            if (idle && m_q.size() != 0) begin
                m_clip  = 1'b1;
                m_age   = 0;
                m_digit = 4'(m_q.pop_front());
            end else if (m_clip) begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (play_done) begin
                    m_clip = 1'b0;
                    m_rest = Gap;
                end else if (m_age == Timeout) begin
                    m_clip = 1'b0;
                    m_rest = Gap;
                    m_to   = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (m_rest > 0) begin
                m_rest--;
            end
            if (valid_in) begin
                if (decision > 4'd9) begin
                    m_bad = 1'b1;
                end else if (Dedup && m_busy && decision == m_last) begin
                    m_bad = m_bad;
                end else if (m_q.size() >= Depth) begin
                    m_ovf = 1'b1;
                end else begin
                    m_q.push_back(int'(decision));
                    m_last = decision;
                end
            end
            m_busy = nxt_busy;
        end
    end

    // Compare every cycle and log each clip start.
    initial forever begin
        logic [8:0] act_v, exp_v;
        logic       prev_rst;
        @(negedge clk);
        if (cmp_en) begin
            act_v = {drv_rst, drv_digit, busy, overflow, bad_digit, timeout};
            exp_v = {!m_clip, m_digit, m_busy, m_ovf, m_bad, m_to};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t: got %b expected %b", $time, act_v, exp_v);
            end
            if (prev_rst === 1'b1 && drv_rst === 1'b0) begin
                clips.push_back(int'(drv_digit));
            end
        end
        prev_rst = drv_rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int d);
        valid_in = 1'b1;
        decision = 4'(d);
        @(negedge clk);
        valid_in = 1'b0;
        decision = 4'd0;
    endtask

    task automatic wait_low(input string name, input int budget);
        int n = 0;
        while (drv_rst !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(drv_rst), 0);
    endtask

    // Play current clip for len cycles, end it, and measure cycles until the next clip starts.
    task automatic play_clip(input int len);
        int n;
        repeat (len) @(negedge clk);
        play_done = 1'b1;
        @(negedge clk);
        play_done = 1'b0;
        n = 1;
        while (drv_rst !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gap done->next start", n, Gap + 2);
    endtask

    task automatic finish_clip(input int len);
        int n = 0;
        repeat (len) @(negedge clk);
        play_done = 1'b1;
        @(negedge clk);
        play_done = 1'b0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle after last clip", int'(busy), 0);
    endtask

    task automatic check_clips(input string name, input int cnt, input int code);
        int c = 0;
        foreach (clips[i]) c = c * 16 + clips[i];
        check({name, " count"}, clips.size(), cnt);
        check({name, " order"}, c, code);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;
        check("reset outputs", int'({drv_rst, drv_digit, busy, overflow, bad_digit, timeout}),
              'h100);

        // Single digit: setup two cycles after the strobe, idle GAP+1 cycles after done.
        clips.delete();
        send(7);
        check("t1 drv_rst held", int'(drv_rst), 1);
        @(negedge clk);
        check("t1 drv_rst fall", int'(drv_rst), 0);
        check("t1 drv_digit", int'(drv_digit), 7);
        repeat (3) @(negedge clk);
        play_done = 1'b1;
        @(negedge clk);
        play_done = 1'b0;
        check("t1 drv_rst after done", int'(drv_rst), 1);
        repeat (Gap) @(negedge clk);
        check("t1 busy in last cycle", int'(busy), 1);
        @(negedge clk);
        check("t1 busy cleared", int'(busy), 0);
        check_clips("t1 clips", 1, 'h7);

        // Queueing: 1..4 fill the queue while 0 plays, 5 overflows.
        clips.delete();
        send(0);
        wait_low("t2 clip0 start", 10);
        for (int d = 1; d <= 5; d++) send(d);
        check("t2 overflow", int'(overflow), 1);
        play_clip(0);
        for (int i = 0; i < 3; i++) play_clip(3);
        finish_clip(3);
        check_clips("t2 clips", 5, 'h01234);

        // Illegal digit: flagged, never queued.
        clips.delete();
        send(12);
        check("t3 bad_digit", int'(bad_digit), 1);
        repeat (4) @(negedge clk);
        check("t3 busy", int'(busy), 0);
        check("t3 drv_rst", int'(drv_rst), 1);
        check_clips("t3 clips", 0, 0);

        // Timeout: one setup plus TIMEOUT play cycles, then the queued digit plays.
        clips.delete();
        send(5);
        send(6);
        wait_low("t4 clip5 start", 10);
        n = 0;
        while (drv_rst === 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4 low cycles", n, Timeout + 1);
        check("t4 timeout flag", int'(timeout), 1);
        n = 0;
        while (drv_rst !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4 rest before next", n, Gap + 1);
        finish_clip(2);
        check_clips("t4 clips", 2, 'h56);

        // Reset mid-play with two queued entries.
        send(1);
        wait_low("t5 clip1 start", 10);
        send(2);
        send(3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t5 outputs after reset",
              int'({drv_rst, drv_digit, busy, overflow, bad_digit, timeout}), 'h100);
        clips.delete();
        repeat (30) @(negedge clk);
        check_clips("t5 clips", 0, 0);
        check("t5 busy", int'(busy), 0);

        // Repeated digit while busy.
        clips.delete();
        send(8);
        wait_low("t6 clip8 start", 10);
        send(3);
        send(3);
        send(4);
        play_clip(1);
        for (int i = 0; i < (Dedup ? 1 : 2); i++) play_clip(2);
        finish_clip(2);
        if (Dedup) check_clips("t6 clips", 3, 'h834);
        else       check_clips("t6 clips", 4, 'h8334);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
